murax_clk_reset_ctrl: RTL and testbench

Reset sequencer that sits directly downstream of the BlackIce PLL wrapper: it drives the PLL's active-low reset, consumes the asynchronous PLL lock flag, and generates the Murax SoC debug and system resets. It releases those resets only after lock has been continuously stable. It re-sequences on lock loss, and optionally restarts the PLL when lock never arrives. Runs on the free-running 100 MHz board reference clock, never on the PLL output.

---
 rtl/murax_clk_reset_pkg.sv | 24 ++
 rtl/murax_sync2.sv | 26 ++
 rtl/murax_clk_reset_ctrl.sv | 152 +++++++++++++++
 tb/tb_murax_clk_reset_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/murax_clk_reset_pkg.sv
// Shared types and constants for the Murax clock/reset sequencer.
// Defaults match the 100 MHz BlackIce board build.
package murax_clk_reset_pkg;

  localparam int unsigned CNT_W   = 17;
  localparam int unsigned FAULT_W = 8;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_SYS_DELAY      = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  function automatic logic [FAULT_W-1:0] sat_inc(input logic [FAULT_W-1:0] v);
    return (v == {FAULT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/murax_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset to a chosen value.
module murax_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/murax_clk_reset_ctrl.sv
// Reset sequencer between the PLL wrapper and the Murax SoC, clocked by the board reference.
// Define MURAX_RESET_CTRL_WATCHDOG_EN to restart the PLL when lock never arrives.
module murax_clk_reset_ctrl
  import murax_clk_reset_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned SYS_DELAY      = DEF_SYS_DELAY,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
  input  logic               io_mainClk,
  input  logic               io_asyncReset,
  input  logic               io_pllLock,
  input  logic               io_buttonReset,
  output logic               io_pllResetn,
  output logic               io_debugReset,
  output logic               io_systemReset,
  output logic               io_locked,
  output logic [FAULT_W-1:0] io_lockFaults
);

  localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SysDelay    = CNT_W'(SYS_DELAY);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);

  logic w_lock_s;
  logic w_btn_s;

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  logic r_pll_resetn;
  logic r_debug_reset;
  logic r_system_reset;
  logic r_locked;
  logic w_pll_resetn_d;
  logic w_debug_reset_d;
  logic w_system_reset_d;
  logic w_locked_d;
  logic w_timeout;

  murax_sync2 #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .i_clk (io_mainClk),
    .i_rst (io_asyncReset),
    .i_d   (io_pllLock),
    .o_q   (w_lock_s)
  );

  murax_sync2 #(
    .RESET_VAL (1'b0)
  ) u_btn_sync (
    .i_clk (io_mainClk),
    .i_rst (io_asyncReset),
    .i_d   (io_buttonReset),
    .o_q   (w_btn_s)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + 1'b1;
    w_timeout = 1'b0;
    unique case (r_state)
      PLL_RST: begin
        if (r_cnt == PllRstLast) w_state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_d = STABLE;
        end else if (r_cnt == TimeoutLast) begin
          w_timeout = 1'b1;
`ifdef MURAX_RESET_CTRL_WATCHDOG_EN
          w_state_d = PLL_RST;
`endif
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_d = WAIT_LOCK;
        end else if (r_cnt == StableLast) begin
          w_state_d = RUN;
        end
      end
      RUN: begin
        // Lock loss takes priority over the button.
        if (!w_lock_s) begin
          w_state_d = WAIT_LOCK;
        end else if (w_btn_s) begin
          w_cnt_d = '0;
        end else if (r_cnt >= SysDelay) begin
          w_cnt_d = SysDelay;
        end
      end
      default: w_state_d = PLL_RST;
    endcase

    if (w_state_d != r_state) w_cnt_d = '0;

    // Outputs are decoded from the next state so they move on the same edge.
    w_pll_resetn_d   = (w_state_d != PLL_RST);
    w_debug_reset_d  = (w_state_d != RUN);
    w_locked_d       = (w_state_d == RUN);
    w_system_reset_d = !((w_state_d == RUN) && !w_btn_s && (w_cnt_d >= SysDelay));
  end

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_state        <= PLL_RST;
      r_cnt          <= '0;
      r_pll_resetn   <= 1'b0;
      r_debug_reset  <= 1'b1;
      r_system_reset <= 1'b1;
      r_locked       <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_pll_resetn   <= w_pll_resetn_d;
      r_debug_reset  <= w_debug_reset_d;
      r_system_reset <= w_system_reset_d;
      r_locked       <= w_locked_d;
    end
  end

`ifdef MURAX_RESET_CTRL_WATCHDOG_EN
  logic [FAULT_W-1:0] r_faults;

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      r_faults <= '0;
    end else if (w_timeout) begin
      r_faults <= sat_inc(r_faults);
    end
  end

  assign io_lockFaults = r_faults;
`else
  // Timeout is decoded but never acted on; lock waits indefinitely.
  logic w_unused_timeout;
  assign w_unused_timeout = w_timeout;
  assign io_lockFaults    = '0;
`endif

  assign io_pllResetn   = r_pll_resetn;
  assign io_debugReset  = r_debug_reset;
  assign io_systemReset = r_system_reset;
  assign io_locked      = r_locked;

endmodule

// File: tb/tb_murax_clk_reset_ctrl.sv
// Self-checking bench for murax_clk_reset_ctrl: directed timing scenarios plus random lock/button
// activity, all compared every cycle against a phase/time-in-phase reference model.
module tb_murax_clk_reset_ctrl;

  localparam int unsigned P = 4;
  localparam int unsigned S = 8;
  localparam int unsigned D = 2;
  localparam int unsigned T = 32;

`ifdef MURAX_RESET_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock = 1'b0;
  logic       btn = 1'b0;
  logic       pll_resetn;
  logic       debug_reset;
  logic       system_reset;
  logic       locked;
  logic [7:0] faults;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  murax_clk_reset_ctrl #(
    .PLL_RST_CYCLES (P),
    .STABLE_CYCLES  (S),
    .SYS_DELAY      (D),
    .LOCK_TIMEOUT   (T)
  ) dut (
    .io_mainClk     (clk),
    .io_asyncReset  (rst),
    .io_pllLock     (lock),
    .io_buttonReset (btn),
    .io_pllResetn   (pll_resetn),
    .io_debugReset  (debug_reset),
    .io_systemReset (system_reset),
    .io_locked      (locked),
    .io_lockFaults  (faults)
  );

  always #5 clk = ~clk;

  // Reference model: which phase we are in and how long we have been there.
  localparam int PhPll = 0, PhWait = 1, PhStable = 2, PhRun = 3;
  int m_phase, m_age, m_faults;
  bit m_lock_pipe[2];
  bit m_btn_pipe[2];

  task automatic model_reset();
    m_phase = PhPll; m_age = 0; m_faults = 0;
    m_lock_pipe[0] = 0; m_lock_pipe[1] = 0;
    m_btn_pipe[0]  = 0; m_btn_pipe[1]  = 0;
  endtask

  task automatic model_step();
    int  nph, nage;
    bit  lk, bt;
    lk = m_lock_pipe[1];
    bt = m_btn_pipe[1];
    nph  = m_phase;
    nage = m_age + 1;
    if (m_phase == PhPll) begin
      if (m_age + 1 == int'(P)) nph = PhWait;
    end else if (m_phase == PhWait) begin
      if (lk) nph = PhStable;
      else if (WD && m_age + 1 == int'(T)) begin
        nph = PhPll;
        m_faults = (m_faults < 255) ? m_faults + 1 : 255;
      end
    end else if (m_phase == PhStable) begin
      if (!lk) nph = PhWait;
      else if (m_age + 1 == int'(S)) nph = PhRun;
    end else begin
      if (!lk) nph = PhWait;
      else if (bt) nage = 0;
      else if (nage > int'(D)) nage = int'(D);
    end
    if (nph != m_phase) nage = 0;
    m_phase = nph;
    m_age   = nage;
    m_lock_pipe[1] = m_lock_pipe[0]; m_lock_pipe[0] = lock;
    m_btn_pipe[1]  = m_btn_pipe[0];  m_btn_pipe[0]  = btn;
  endtask

  function automatic logic [11:0] model_vec();
    logic [7:0] f;
    f = 8'(m_faults);
    return {m_phase != PhPll, m_phase != PhRun,
            !(m_phase == PhRun && m_age >= int'(D)), m_phase == PhRun, f};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {pll_resetn, debug_reset, system_reset, locked, faults};
  endfunction

  task automatic check_vec(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (pllRn,dbg,sys,lck,faults)", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    edge_n++;
    if (rst) model_reset();
    else model_step();
    #1;
    check_vec(tag, dut_vec(), model_vec());
  endtask

  int t_pll, t_dbg, t_sys, t_rise, n;
  bit saw, prev_pll;

  task automatic powerup(input string tag);
    edge_n = 0; t_pll = -1; t_dbg = -1; t_sys = -1;
    for (int i = 0; i < 30; i++) begin
      tick(tag);
      if (t_pll < 0 && pll_resetn)    t_pll = edge_n;
      if (t_dbg < 0 && !debug_reset)  t_dbg = edge_n;
      if (t_sys < 0 && !system_reset) t_sys = edge_n;
    end
    // Lock is already synchronized when WAIT_LOCK is entered, so it lasts one cycle.
    check_int({tag, "_pll_release"}, t_pll, int'(P));
    check_int({tag, "_debug_release"}, t_dbg, int'(P + 1 + S));
    check_int({tag, "_sys_release"}, t_sys, int'(P + 1 + S + D));
  endtask

  initial begin
    model_reset();
    lock = 1'b1;
    #1 rst = 1'b1;
    #1 check_vec("reset_values", dut_vec(), 12'b0110_0000_0000);
    tick("in_reset");
    tick("in_reset");
    rst = 1'b0;
    powerup("powerup");

    // Short lock pulse while stabilizing must not release anything.
    lock = 1'b0;
    for (int i = 0; i < 6; i++) tick("lock_low");
    lock = 1'b1;
    saw = 0;
    for (int i = 0; i < 5; i++) begin tick("lock_pulse"); if (!debug_reset) saw = 1; end
    lock = 1'b0;
    for (int i = 0; i < 10; i++) begin tick("lock_pulse_end"); if (!debug_reset) saw = 1; end
    check_int("glitch_no_release", int'(saw), 0);

    // Lock loss in RUN, then recovery.
    lock = 1'b1;
    for (int i = 0; i < 20; i++) tick("to_run");
    lock = 1'b0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick("lock_loss");
      if (n < 0 && debug_reset && system_reset && !locked) n = i;
    end
    check_int("lock_loss_latency", n, 3);
    lock = 1'b1;
    edge_n = 0; t_dbg = -1; t_sys = -1;
    for (int i = 0; i < 40; i++) begin
      tick("relock");
      if (t_dbg < 0 && !debug_reset)  t_dbg = edge_n;
      if (t_sys < 0 && !system_reset) t_sys = edge_n;
    end
    check_int("relock_debug_release", t_dbg, int'(3 + S));
    check_int("relock_sys_release", t_sys, int'(3 + S + D));

    // Three-cycle button press in RUN.
    btn = 1'b1;
    edge_n = 0; t_rise = -1; t_sys = -1; saw = 0;
    for (int i = 1; i <= 12; i++) begin
      tick("button");
      if (i == 3) btn = 1'b0;
      if (debug_reset) saw = 1;
      if (t_rise < 0 && system_reset) t_rise = edge_n;
      if (t_rise >= 0 && t_sys < 0 && !system_reset) t_sys = edge_n;
    end
    check_int("button_sys_assert", t_rise, 3);
    check_int("button_sys_release", t_sys, int'(2 + 3 + D));
    check_int("button_debug_held", int'(saw), 0);

    // Lock never returns: watchdog restarts the PLL, otherwise waits forever.
    lock = 1'b0;
    n = 0; prev_pll = pll_resetn;
    for (int i = 0; i < int'(256 * (P + T) + T); i++) begin
      tick("no_lock");
      if (prev_pll && !pll_resetn) n++;
      prev_pll = pll_resetn;
    end
    check_int("pll_restarts", n, WD ? ((256 * (P + T) + T - 3 - T) / (P + T) + 1) : 0);
    check_int("lock_faults_final", int'(faults), WD ? 255 : 0);

    // Asynchronous reset while running.
    lock = 1'b1;
    for (int i = 0; i < 20; i++) tick("to_run2");
    check_int("in_run_before_reset", int'(locked), 1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_vec("async_reset_in_run", dut_vec(), 12'b0110_0000_0000);
    tick("in_reset2");
    rst = 1'b0;
    powerup("repowerup");

    // Random lock glitches and button presses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      if ($urandom_range(0, 63) == 0) btn = ~btn;
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
